// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder; token valid WIN_DEPTH+1 cycles after the fill-completing accept.
// Backpressure: tok_ready low holds EMIT indefinitely; in_ready is only high in FILL.
module lz77_stream_encoder #(
  parameter int DATA_W    = 8,
  parameter int WIN_DEPTH = 16,
  parameter int LA_DEPTH  = 4,
  localparam int OFF_W    = $clog2(WIN_DEPTH),
  localparam int LEN_W    = $clog2(LA_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_last,
  output logic                            tok_valid,
  input  logic                            tok_ready,
  output logic [OFF_W+LEN_W+DATA_W-1:0]   tok_data,
  output logic                            tok_last,
  output logic                            busy,
  output logic                            done
);
  localparam int CNT_W = $clog2(LA_DEPTH + 2);
  localparam int WC_W  = $clog2(WIN_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, FILL, SEARCH, EMIT, SLIDE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] win [WIN_DEPTH];
  logic [DATA_W-1:0] la  [LA_DEPTH+1];
  logic [WC_W-1:0]   win_cnt;
  logic [CNT_W-1:0]  la_cnt, la_cnt_acc, slide_rem;
  logic              last_seen, last_acc, acc;
  logic [OFF_W-1:0]  d_idx, best_off, fin_off, widx;
  logic [LEN_W-1:0]  best_len, cand_len, fin_len, tok_len;
  logic              run, better, search_end, slide_end;
  int                cap_i;

  assign in_ready   = (state == FILL) && (la_cnt < CNT_W'(LA_DEPTH + 1)) && !last_seen;
  assign busy       = (state != IDLE);
  assign acc        = in_valid && in_ready;
  assign la_cnt_acc = la_cnt + CNT_W'(acc);
  assign last_acc   = last_seen || (acc && in_last);
  assign search_end = (state == SEARCH) && (d_idx == OFF_W'(WIN_DEPTH - 1));
  assign slide_end  = (state == SLIDE) && (slide_rem == CNT_W'(1));

  // Match length at distance d_idx+1; history at distance d-k sits in win[d_idx-k].
  always_comb begin
    cap_i = int'(la_cnt) - 1;
    if (cap_i > LA_DEPTH) cap_i = LA_DEPTH;
    cand_len = '0;
    run      = 1'b1;
    widx     = '0;
    for (int k = 0; k < LA_DEPTH; k++) begin
      widx = d_idx - OFF_W'(k);
      if (run && (k <= int'(d_idx)) && (k < cap_i) && (int'(d_idx) < int'(win_cnt)) &&
          (la[k] == win[widx]))
        cand_len = LEN_W'(k + 1);
      else
        run = 1'b0;
    end
  end

  // Strictly-longer wins, so scanning d upward keeps the smallest d on ties.
  assign better  = (cand_len > best_len);
  assign fin_len = better ? cand_len : best_len;
  assign fin_off = better ? d_idx : best_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = FILL;
      FILL: begin
        if (last_seen && (la_cnt == '0))
          state_nxt = IDLE;
        else if ((la_cnt_acc == CNT_W'(LA_DEPTH + 1)) || (last_acc && (la_cnt_acc != '0)))
          state_nxt = SEARCH;
      end
      SEARCH: if (search_end) state_nxt = EMIT;
      EMIT:   if (tok_ready) state_nxt = SLIDE;
      SLIDE:  if (slide_end) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
      for (int i = 0; i <= LA_DEPTH; i++) la[i] <= '0;
      win_cnt   <= '0;
      la_cnt    <= '0;
      last_seen <= 1'b0;
      d_idx     <= '0;
      best_len  <= '0;
      best_off  <= '0;
      tok_len   <= '0;
      slide_rem <= '0;
      tok_valid <= 1'b0;
      tok_data  <= '0;
      tok_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == FILL) && (state_nxt == IDLE);
      case (state)
        IDLE: if (start) begin
          win_cnt   <= '0;
          la_cnt    <= '0;
          last_seen <= 1'b0;
        end
        FILL: begin
          if (acc) begin
            la[la_cnt] <= in_data;
            la_cnt     <= la_cnt_acc;
            if (in_last) last_seen <= 1'b1;
          end
          if (state_nxt == SEARCH) begin
            d_idx    <= '0;
            best_len <= '0;
            best_off <= '0;
          end
        end
        SEARCH: begin
          if (better) begin
            best_len <= cand_len;
            best_off <= d_idx;
          end
          d_idx <= d_idx + OFF_W'(1);
          if (search_end) begin
            tok_valid <= 1'b1;
            tok_data  <= {fin_off, fin_len, la[fin_len]};
            tok_last  <= last_seen && (int'(la_cnt) == int'(fin_len) + 1);
            tok_len   <= fin_len;
          end
        end
        EMIT: if (tok_ready) begin
          tok_valid <= 1'b0;
          slide_rem <= CNT_W'(tok_len) + CNT_W'(1);
        end
        SLIDE: begin
          win[0] <= la[0];
          for (int i = 1; i < WIN_DEPTH; i++) win[i] <= win[i-1];
          for (int i = 0; i < LA_DEPTH; i++) la[i] <= la[i+1];
          la[LA_DEPTH] <= '0;
          la_cnt       <= la_cnt - CNT_W'(1);
          slide_rem    <= slide_rem - CNT_W'(1);
          if (win_cnt != WC_W'(WIN_DEPTH)) win_cnt <= win_cnt + WC_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/lz77_stream_encoder.md
# lz77_stream_encoder

Parametrised, streaming LZ77 encoder for the compressor datapath. It accepts symbols over a valid/ready input stream and keeps a sliding history window and a lookahead buffer. It searches the window one candidate offset per cycle and emits {offset, length, next} tokens over a valid/ready output with backpressure. It supports configurable symbol width, window depth and lookahead depth, and marks the last token of each block.

## Interface
- DATA_W, 8, symbol width
- WIN_DEPTH, 16, history window entries (power of 2, ≥2)
- LA_DEPTH, 4, maximum match length; the lookahead buffer holds LA_DEPTH+1 symbols
- OFF_W, clog2(WIN_DEPTH), offset field width (derived)
- LEN_W, clog2(LA_DEPTH+1), length field width (derived)
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a block; ignored unless in IDLE
- in_valid / in_ready  in / out  1  input handshake; a symbol is accepted when both are high
- in_data  in  DATA_W  input symbol
- in_last  in  1  marks the final symbol of the block; qualified by the handshake
- tok_valid / tok_ready  out / in  1  token handshake
- tok_data  out  OFF_W+LEN_W+DATA_W  token layout {offset, length, next}
- tok_last  out  1  marks the final token of the block
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final token is accepted

## Operation
- **States:** IDLE, FILL, SEARCH, EMIT, SLIDE.
- **IDLE:** start clears the window count, the lookahead count and the last-seen flag, then moves to FILL.
- **FILL:**
  - in_ready = (la_cnt < LA_DEPTH+1) and no last-seen flag. Accepted symbols append to the lookahead.
  - Go to SEARCH when la_cnt = LA_DEPTH+1, or when last has been seen and la_cnt > 0.
  - Go to IDLE with a done pulse when last has been seen and la_cnt = 0.
- **SEARCH:**
  - Candidate distance d runs 1..WIN_DEPTH, one per cycle. Candidates with d > win_cnt score 0.
  - For a candidate, len(d) is the longest prefix where la[k] equals the history symbol at distance d−k, for k < d (no overlap into the lookahead).
  - len(d) is capped at min(LA_DEPTH, la_cnt−1), so a next symbol always remains.
  - The best candidate is the one with the strictly longest length; on a tie, the smallest d wins.
- **Token fields:**
  - offset = d−1, or 0 when length = 0.
  - next = la[length].
  - tok_last = 1 when last has been seen and la_cnt = length+1.
- **EMIT:** tok_valid holds with tok_data and tok_last stable until tok_ready is sampled high.
- **SLIDE:**
  - Shift length+1 symbols, one per cycle, from the lookahead head into the window at d=1.
  - The oldest window entry drops off; win_cnt saturates at WIN_DEPTH.
  - After SLIDE, return to FILL.
- A start pulse outside IDLE has no effect.
- Reset mid-operation returns to IDLE, clears all buffers and counts, and drops any token in flight.

## Timing
- **Reset values:** in_ready, tok_valid, tok_data, tok_last, busy and done are all 0.
- **Start:** start in IDLE gives busy=1 and in_ready=1 on the next cycle.
- **SEARCH duration:** SEARCH is entered the cycle after the accept that fills the lookahead, or after the FILL exit condition. It lasts exactly WIN_DEPTH cycles regardless of win_cnt.
- **Token timing:** tok_valid rises on the cycle after SEARCH ends and is registered. Latency from the fill-completing accept to tok_valid is WIN_DEPTH+1 cycles.
- **Token accept:** the handshake takes 1 cycle; SLIDE follows for length+1 cycles, then FILL.
- **Done:** done pulses exactly 1 cycle, on the cycle FILL observes an empty lookahead after last; busy falls on that same cycle.
- **Input gating:** in_ready=0 in SEARCH, EMIT, SLIDE and IDLE, even when in_valid=1.
- **Backpressure:** tok_ready low stalls EMIT indefinitely, with no state or data change.

## Test plan
- **Reset:** drive rst=0 asynchronously mid-clock. All outputs go to 0 immediately. Release, pulse start, and in_ready=1 on the next cycle.
- **Basic match** (defaults): stream "ABCABCX" (0x41,0x42,0x43,0x41,0x42,0x43,0x58) with last on 0x58. Tokens in order: {0,0,0x41}, {0,0,0x42}, {0,0,0x43}, {offset=2,len=3,0x58} with tok_last=1. A done pulse follows.
- **Non-overlap and length cap:** stream "AAAAA" with last. Tokens: {0,0,0x41}, {0,1,0x41}, {0,1,0x41}, with tok_last on the third.
- **Window eviction:** stream 0x00..0x13, then 0x03 and 0x04 with last. The final two tokens are {0,0,0x03} and {0,0,0x04} (distance > WIN_DEPTH never matches).
- **Backpressure:** hold tok_ready=0 for 10 cycles during EMIT. tok_valid stays 1 and tok_data is unchanged; in_ready stays 0. The token is accepted on the cycle tok_ready=1.
- **Reset during SEARCH, and start while busy:** a start pulse during SEARCH is ignored (token stream unchanged). rst=0 during SEARCH forces IDLE with no token. A fresh block then encodes correctly from an empty window.
